alu_arbiter: RTL and testbench

//  Shares one 32-bit ALU between two requesters (port 0: execute stage, port 1: address/aux unit).

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared ALU: grant -> S1 operand registers -> S2 per-port
// response registers. Round-robin or fixed-priority, one accept per cycle, two-cycle latency.

module alu_arbiter_rsp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             zero_i,
  input  logic             err_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);
  logic [WIDTH-1:0] result_q;
  logic             zero_q, err_q;

  // Response fields hold their last value until this port owns the next S2 slot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (cap_i) begin
      result_q <= result_i;
      zero_q   <= zero_i;
      err_q    <= err_i;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int RR    = 1,
  parameter int MAXOP = 9
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             m0_valid_i,
  output logic             m0_ready_o,
  input  logic [WIDTH-1:0] m0_a_i,
  input  logic [WIDTH-1:0] m0_b_i,
  input  logic [OPW-1:0]   m0_op_i,
  output logic             m0_rsp_valid_o,
  output logic [WIDTH-1:0] m0_rsp_result_o,
  output logic             m0_rsp_zero_o,
  output logic             m0_rsp_err_o,
  input  logic             m1_valid_i,
  output logic             m1_ready_o,
  input  logic [WIDTH-1:0] m1_a_i,
  input  logic [WIDTH-1:0] m1_b_i,
  input  logic [OPW-1:0]   m1_op_i,
  output logic             m1_rsp_valid_o,
  output logic [WIDTH-1:0] m1_rsp_result_o,
  output logic             m1_rsp_zero_o,
  output logic             m1_rsp_err_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i
);
  localparam int NP     = 2;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
  } rsp_t;

  req_t [NP-1:0]    req;
  rsp_t [NP-1:0]    rsp;
  rsp_t             s2_d;
  logic [NP-1:0]    valid, grant, cap, rsp_valid;
  logic             accept, sel;
  logic             last_grant_q;
  req_t             s1_q;
  logic             s1_own_q, s1_err_q, s2_own_q;
  logic [STAGES:1]  vld_pipe_q;

  assign req[0]   = '{a: m0_a_i, b: m0_b_i, op: m0_op_i};
  assign req[1]   = '{a: m1_a_i, b: m1_b_i, op: m1_op_i};
  assign valid    = {m1_valid_i, m0_valid_i};

  // On a tie the port that did not win last goes; last_grant resets to 1 so port 0 wins first.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      if (RR != 0 && !last_grant_q) grant = 2'b10;
      else                          grant = 2'b01;
    end
    if (!rst_n_i) grant = '0;
  end

  assign accept     = |grant;
  assign sel        = grant[1];
  assign m0_ready_o = grant[0];
  assign m1_ready_o = grant[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
      s1_q         <= '0;
      s1_own_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      s2_own_q     <= 1'b0;
      vld_pipe_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], accept};
      if (accept) begin
        s1_q     <= req[sel];
        s1_own_q <= sel;
        s1_err_q <= req[sel].op > OPW'(MAXOP);
        if (RR != 0) last_grant_q <= sel;
      end
      if (vld_pipe_q[1]) s2_own_q <= s1_own_q;
    end
  end

  assign alu_a_o       = s1_q.a;
  assign alu_b_o       = s1_q.b;
  assign alu_control_o = s1_q.op;

  // Illegal ops still travel through the ALU, but the reply is pinned to result 0 / zero 1.
  assign s2_d.result = s1_err_q ? '0 : alu_result_i;
  assign s2_d.zero   = s1_err_q | alu_zero_i;
  assign s2_d.err    = s1_err_q;

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign cap[i]       = vld_pipe_q[1] && (s1_own_q == 1'(i));
    assign rsp_valid[i] = vld_pipe_q[STAGES] && (s2_own_q == 1'(i));

    alu_arbiter_rsp #(.WIDTH(WIDTH)) u_rsp (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .cap_i    (cap[i]),
      .result_i (s2_d.result),
      .zero_i   (s2_d.zero),
      .err_i    (s2_d.err),
      .result_o (rsp[i].result),
      .zero_o   (rsp[i].zero),
      .err_o    (rsp[i].err)
    );
  end

  assign m0_rsp_valid_o  = rsp_valid[0];
  assign m0_rsp_result_o = rsp[0].result;
  assign m0_rsp_zero_o   = rsp[0].zero;
  assign m0_rsp_err_o    = rsp[0].err;
  assign m1_rsp_valid_o  = rsp_valid[1];
  assign m1_rsp_result_o = rsp[1].result;
  assign m1_rsp_zero_o   = rsp[1].zero;
  assign m1_rsp_err_o    = rsp[1].err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: RR instance driven from a vector table plus corner sequences,
// fixed-priority instance for the priority case; scoreboard queues check data and latency.

module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid = 0, m1_valid = 0, m0_ready, m1_ready;
  logic [31:0] m0_a = 0, m0_b = 0, m1_a = 0, m1_b = 0;
  logic [3:0]  m0_op = 0, m1_op = 0;
  logic        m0_rsp_valid, m0_rsp_zero, m0_rsp_err, m1_rsp_valid, m1_rsp_zero, m1_rsp_err;
  logic [31:0] m0_rsp_result, m1_rsp_result, alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctl;
  logic        alu_zero;

  logic        f_m0_valid = 0, f_m1_valid = 0, f_m0_ready, f_m1_ready;
  logic        f_m0_rsp_valid, f_m0_rsp_zero, f_m0_rsp_err, f_m1_rsp_valid, f_m1_rsp_zero, f_m1_rsp_err;
  logic [31:0] f_m0_rsp_result, f_m1_rsp_result, f_alu_a, f_alu_b, f_alu_res;
  logic [3:0]  f_alu_ctl;
  logic        f_alu_zero;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'b0, $signed(a) < $signed(b)};
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $unsigned($signed(a) >>> b[4:0]);
      4'd9: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_res    = alu_f(alu_a, alu_b, alu_ctl);
    alu_zero   = (alu_res == 32'h0);
    f_alu_res  = alu_f(f_alu_a, f_alu_b, f_alu_ctl);
    f_alu_zero = (f_alu_res == 32'h0);
  end

  alu_arbiter #(.WIDTH(32), .OPW(4), .RR(1), .MAXOP(9)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_a_i(m0_a), .m0_b_i(m0_b), .m0_op_i(m0_op),
    .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_result_o(m0_rsp_result), .m0_rsp_zero_o(m0_rsp_zero),
    .m0_rsp_err_o(m0_rsp_err),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_a_i(m1_a), .m1_b_i(m1_b), .m1_op_i(m1_op),
    .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_result_o(m1_rsp_result), .m1_rsp_zero_o(m1_rsp_zero),
    .m1_rsp_err_o(m1_rsp_err),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_control_o(alu_ctl),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero)
  );

  alu_arbiter #(.WIDTH(32), .OPW(4), .RR(0), .MAXOP(9)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_valid_i(f_m0_valid), .m0_ready_o(f_m0_ready), .m0_a_i(32'd1), .m0_b_i(32'd1), .m0_op_i(4'd0),
    .m0_rsp_valid_o(f_m0_rsp_valid), .m0_rsp_result_o(f_m0_rsp_result), .m0_rsp_zero_o(f_m0_rsp_zero),
    .m0_rsp_err_o(f_m0_rsp_err),
    .m1_valid_i(f_m1_valid), .m1_ready_o(f_m1_ready), .m1_a_i(32'd2), .m1_b_i(32'd2), .m1_op_i(4'd0),
    .m1_rsp_valid_o(f_m1_rsp_valid), .m1_rsp_result_o(f_m1_rsp_result), .m1_rsp_zero_o(f_m1_rsp_zero),
    .m1_rsp_err_o(f_m1_rsp_err),
    .alu_a_o(f_alu_a), .alu_b_o(f_alu_b), .alu_control_o(f_alu_ctl),
    .alu_result_i(f_alu_res), .alu_zero_i(f_alu_zero)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          gnt_log[$];
  int          cyc = 0, rsp_cnt = 0;
  int          f_acc0 = 0, f_acc1 = 0, f_rsp0 = 0, f_rsp1 = 0;
  logic [31:0] e_res[2];
  logic        e_zero[2], e_err[2];

  task automatic rsp_chk(input string p, input exp_t e, input logic [31:0] r, input logic z,
                         input logic er, input int now);
    chk({p, "_result"}, r, e.res);
    chk({p, "_zero"}, 32'(z), 32'(e.zero));
    chk({p, "_err"}, 32'(er), 32'(e.err));
    chk({p, "_latency"}, 32'(now - e.cyc), 32'd2);
  endtask

  // Scoreboard: push on handshake, pop and compare on response.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (m0_ready || m1_ready || m0_valid || m1_valid) begin
        chk("one_ready", 32'(m0_ready & m1_ready), 32'd0);
        chk("ready_wo_valid", 32'((m0_ready & ~m0_valid) | (m1_ready & ~m1_valid)), 32'd0);
      end
      if (m0_valid && m0_ready) begin
        q0.push_back('{e_res[0], e_zero[0], e_err[0], cyc});
        gnt_log.push_back(0);
      end
      if (m1_valid && m1_ready) begin
        q1.push_back('{e_res[1], e_zero[1], e_err[1], cyc});
        gnt_log.push_back(1);
      end
      if (m0_rsp_valid) begin
        rsp_cnt++;
        chk("m0_rsp_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) rsp_chk("m0", q0.pop_front(), m0_rsp_result, m0_rsp_zero, m0_rsp_err, cyc);
      end
      if (m1_rsp_valid) begin
        rsp_cnt++;
        chk("m1_rsp_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) rsp_chk("m1", q1.pop_front(), m1_rsp_result, m1_rsp_zero, m1_rsp_err, cyc);
      end
      if (f_m0_valid && f_m0_ready) f_acc0++;
      if (f_m1_valid && f_m1_ready) f_acc1++;
      if (f_m0_rsp_valid) f_rsp0++;
      if (f_m1_rsp_valid) f_rsp1++;
    end
  end

  task automatic drv(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [31:0] r, input logic z, input logic e);
    if (p == 0) begin m0_valid = 1; m0_a = a; m0_b = b; m0_op = op; end
    else        begin m1_valid = 1; m1_a = a; m1_b = b; m1_op = op; end
    e_res[p] = r; e_zero[p] = z; e_err[p] = e;
  endtask

  // Single request on an otherwise idle arbiter: ready must come in the first cycle.
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] r, input logic z, input logic e);
    int   w;
    logic rdy;
    w = 0;
    @(posedge clk); #1;
    drv(p, a, b, op, r, z, e);
    do begin
      @(negedge clk);
      rdy = (p == 0) ? m0_ready : m1_ready;
      w++;
    end while (!rdy && w < 20);
    chk("ready_same_cycle", 32'(w), 32'd1);
    @(posedge clk); #1;
    m0_valid = 0; m1_valid = 0;
  endtask

  task automatic drain_chk(input string name);
    repeat (3) @(posedge clk);
    #1 chk(name, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  typedef struct {
    int          p;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] r;
    logic        z, e;
  } vec_t;

  vec_t vt[13];

  initial begin
    int snap;
    vt[0]  = '{0, 32'd5,        32'd7,        4'd0,  32'd12,       1'b0, 1'b0};
    vt[1]  = '{1, 32'd1,        32'd1,        4'd12, 32'd0,        1'b1, 1'b1};
    vt[2]  = '{1, 32'd3,        32'd4,        4'd0,  32'd7,        1'b0, 1'b0};
    vt[3]  = '{0, 32'd9,        32'd9,        4'd1,  32'd0,        1'b1, 1'b0};
    vt[4]  = '{1, 32'hF0,       32'h0F,       4'd3,  32'hFF,       1'b0, 1'b0};
    vt[5]  = '{0, 32'h80000000, 32'd4,        4'd8,  32'hF8000000, 1'b0, 1'b0};
    vt[6]  = '{0, 32'd1,        32'd2,        4'd9,  32'd1,        1'b0, 1'b0};
    vt[7]  = '{0, 32'hFFFFFFFF, 32'd1,        4'd5,  32'd1,        1'b0, 1'b0};
    vt[8]  = '{1, 32'd1,        32'd31,       4'd6,  32'h80000000, 1'b0, 1'b0};
    vt[9]  = '{1, 32'h80000000, 32'd31,       4'd7,  32'd1,        1'b0, 1'b0};
    vt[10] = '{0, 32'hAAAA,     32'hAAAA,     4'd4,  32'd0,        1'b1, 1'b0};
    vt[11] = '{0, 32'hF0F0,     32'hFF00,     4'd2,  32'hF000,     1'b0, 1'b0};
    vt[12] = '{1, 32'd7,        32'd3,        4'd15, 32'd0,        1'b1, 1'b1};

    // Reset values
    #12;
    chk("rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
    chk("rst_rsp_flags", 32'({m0_rsp_zero, m0_rsp_err, m1_rsp_zero, m1_rsp_err}), 32'd0);
    chk("rst_m0_result", m0_rsp_result, 32'd0);
    chk("rst_m1_result", m1_rsp_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // Table-driven single requests
    for (int i = 0; i < 13; i++) begin
      send(vt[i].p, vt[i].a, vt[i].b, vt[i].op, vt[i].r, vt[i].z, vt[i].e);
      drain_chk("vec_drained");
    end

    // Round-robin from a fresh reset: grants alternate starting with port 0
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    gnt_log.delete();
    @(posedge clk); #1;
    drv(0, 32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0);
    drv(1, 32'hF0, 32'h0F, 4'd3, 32'hFF, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    chk("rr_grant_count", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      chk("rr_grant0", 32'(gnt_log[0]), 32'd0);
      chk("rr_grant1", 32'(gnt_log[1]), 32'd1);
      chk("rr_grant2", 32'(gnt_log[2]), 32'd0);
      chk("rr_grant3", 32'(gnt_log[3]), 32'd1);
    end
    drain_chk("rr_drained");

    // Fixed priority: port 0 starves port 1 until it drops valid
    @(posedge clk); #1 f_m0_valid = 1; f_m1_valid = 1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 f_m0_valid = 0;
    @(negedge clk) chk("fp_m1_after_drop", 32'(f_m1_ready), 32'd1);
    @(posedge clk); #1 f_m1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("fp_m0_accepts", 32'(f_acc0), 32'd4);
    chk("fp_m1_accepts", 32'(f_acc1), 32'd1);
    chk("fp_m0_rsps", 32'(f_rsp0), 32'd4);
    chk("fp_m1_rsps", 32'(f_rsp1), 32'd1);
    chk("fp_m1_result", f_m1_rsp_result, 32'd4);

    // Back-to-back SRA then SLTU on port 0; idle S1 then holds the last operands
    @(posedge clk); #1 drv(0, 32'h80000000, 32'd4, 4'd8, 32'hF8000000, 1'b0, 1'b0);
    @(posedge clk); #1 drv(0, 32'd1, 32'd2, 4'd9, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1 m0_valid = 0;
    drain_chk("b2b_drained");
    repeat (2) @(posedge clk);
    #1;
    chk("idle_hold_alu_a", alu_a, 32'd1);
    chk("idle_hold_alu_ctl", 32'(alu_ctl), 32'd9);

    // Reset while S1 and S2 both hold requests
    @(posedge clk); #1 drv(0, 32'd1, 32'd2, 4'd0, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1 drv(0, 32'd5, 32'd6, 4'd13, 32'd0, 1'b1, 1'b1);
    @(posedge clk); #1 m0_valid = 0;
    chk("pre_rst_rsp_valid", 32'(m0_rsp_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("midrst_rsp_valid", 32'(m0_rsp_valid), 32'd0);
    chk("midrst_result", m0_rsp_result, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_ctl", 32'(alu_ctl), 32'd0);
    snap = rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1 chk("no_rsp_after_rst", 32'(rsp_cnt - snap), 32'd0);
    send(0, 32'd2, 32'd3, 4'd0, 32'd5, 1'b0, 1'b0);
    drain_chk("post_rst_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
